demux_dispatcher: RTL
=====================

DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter BURST_LEN, default 4: beats sent to one channel before the channel may change; legal range 1..255.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 en_i  input  1  dispatch enable; 0 blocks acceptance of new beats.
REQ-006 mode_i  input  1  0 = round-robin channel selection, 1 = fixed channel from dest_i.
REQ-007 dest_i  input  2  target channel in fixed mode.
REQ-008 s_valid_i  input  1  upstream beat valid.
REQ-009 s_ready_o  output  1  dispatcher can accept a beat.
REQ-010 s_data_i  input  DATA_W  upstream payload.
REQ-011 m_valid_o  output  4  per-channel valid, at most one bit high.
REQ-012 m_ready_i  input  4  per-channel ready.
REQ-013 m_data_o  output  DATA_W  held payload, shared by all channels.
REQ-014 sel_o  output  2  current channel index; drives the demux select.
REQ-015 busy_o  output  1  high while a beat is held or a burst is incomplete.

Function
REQ-016 FSM states: IDLE (output register empty), HOLD (one beat held); no other states.
REQ-017 IDLE: s_ready_o = en_i; m_valid_o = 0.
REQ-018 IDLE, s_valid_i & s_ready_o at edge N: capture s_data_i into m_data_o; enter HOLD; m_valid_o[sel_o] high from cycle N+1 (latency 1).
REQ-019 First beat of a burst (beat counter = 0): at acceptance, sel_o loads dest_i if mode_i = 1, else the round-robin pointer.
REQ-020 HOLD: s_ready_o = 0; m_data_o and sel_o stable; m_valid_o[sel_o] = 1 until m_ready_i[sel_o] = 1 on an edge.
REQ-021 m_ready_i bits other than m_ready_i[sel_o] have no effect.
REQ-022 HOLD handshake at edge: return to IDLE; beat counter increments; if counter = BURST_LEN-1, counter clears to 0 and round-robin pointer becomes sel_o+1 mod 4 (3 wraps to 0).
REQ-023 Round-robin pointer advances only on burst completion and only for bursts accepted with mode_i = 0.
REQ-024 mode_i and dest_i are sampled only at first-beat acceptance; changes mid-burst take effect on the next burst.
REQ-025 en_i deassertion in HOLD does not cancel the held beat; the beat completes; the beat counter is preserved and the burst resumes when en_i returns.
REQ-026 Maximum throughput: one beat per 2 cycles (accept cycle, handshake cycle).
REQ-027 busy_o = (state = HOLD) | (beat counter != 0).
REQ-028 BURST_LEN = 1: every beat is a burst; round-robin pointer advances after every handshake.

Reset
REQ-029 rst_i high forces, asynchronously: state IDLE, m_valid_o = 0, m_data_o = 0, sel_o = 0, round-robin pointer = 0, beat counter = 0, busy_o = 0.
REQ-030 Reset asserted in HOLD discards the held beat with no handshake; after release the first burst goes to channel 0 (mode_i = 0).

Structure
REQ-031 Shared package demux_pkg holds NUM_CH = 4, SEL_W = 2, the FSM state enum (IDLE, HOLD) and the BURST_LEN default.
REQ-032 One sub-module: demux1x4, instantiated with x_i = held-valid and sel_i = sel_o to produce m_valid_o.

Verification
REQ-033 mode_i=0, BURST_LEN=4, all m_ready_i=1, 16 beats 0x00..0x0F -> ch0 gets 0x00-0x03, ch1 0x04-0x07, ch2 0x08-0x0B, ch3 0x0C-0x0F; pointer returns to 0.
REQ-034 mode_i=1, dest_i=2, 8 beats -> all on m_valid_o[2]; toggle dest_i to 1 after beat 2 -> beats 0-3 on ch2, 4-7 on ch1.
REQ-035 Beat 0xA5 held to ch0, m_ready_i=4'b1110 for 5 cycles then 4'b0001 -> m_valid_o=4'b0001 and m_data_o=0xA5 stable for 6 cycles; s_ready_o=0 throughout.
REQ-036 en_i=0 after beat 1 of a burst -> beat completes, s_ready_o=0, busy_o=1; en_i=1 -> remaining 2 beats go to the same channel.
REQ-037 rst_i pulsed asynchronously mid-HOLD on ch3 -> m_valid_o=0 and sel_o=0 immediately; next beat goes to ch0.
REQ-038 BURST_LEN=1, mode_i=0, 5 beats -> channels 0,1,2,3,0 (wrap-around).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the demux dispatcher.
// Contents: channel count, select width, FSM state encoding and the
// default burst length used by the dispatcher top level.
package demux_pkg;

  localparam int NUM_CH        = 4;
  localparam int SEL_W         = 2;
  localparam int BURST_LEN_DEF = 4;

  // Output register is either empty (IDLE) or holds one beat (HOLD).
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/demux1x4.sv
// One-hot 1-to-4 demultiplexer.
// Ports:
//   x_i   - input bit to route
//   sel_i - output index that receives x_i
//   y_o   - outputs; only y_o[sel_i] may be high
module demux1x4
  import demux_pkg::*;
(
  input  logic              x_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [NUM_CH-1:0] y_o
);

  // Route x_i onto the selected output, all other outputs low.
  always_comb begin
    y_o = 4'b0000;
    case (sel_i)
      2'd0:    y_o = {3'b000, x_i};
      2'd1:    y_o = {2'b00, x_i, 1'b0};
      2'd2:    y_o = {1'b0, x_i, 2'b00};
      2'd3:    y_o = {x_i, 3'b000};
      default: y_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/demux_dispatcher.sv
// Burst dispatcher: accepts one upstream beat at a time into a single
// output register and presents it on one of four channels, chosen either
// round-robin per burst or from dest_i per burst.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   en_i                - allows acceptance of new beats
//   mode_i, dest_i      - 0: round-robin, 1: fixed channel dest_i
//   s_valid_i/s_ready_o/s_data_i - upstream handshake and payload
//   m_valid_o/m_ready_i - per-channel handshake
//   m_data_o            - held payload, shared by all channels
//   sel_o               - current channel index
//   busy_o              - beat held or burst still open
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [SEL_W-1:0]  dest_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [NUM_CH-1:0] m_valid_o,
  input  logic [NUM_CH-1:0] m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              busy_o
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  rr_ptr_r;
  logic [7:0]        beat_cnt_r;
  logic              burst_fixed_r;   // current burst was opened in fixed mode
  logic              accept_s;
  logic              handshake_s;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode, upstream ready and handshake strobes.
  always_comb begin
    state_nxt_s = state_r;
    s_ready_o   = 1'b0;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        s_ready_o = en_i;
        accept_s  = s_valid_i & en_i;
        if (accept_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        // Only the ready of the selected channel can release the beat.
        handshake_s = m_ready_i[sel_r];
        if (handshake_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Payload capture, per-burst channel choice, beat counting and pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_r        <= '0;
      sel_r         <= 2'd0;
      rr_ptr_r      <= 2'd0;
      beat_cnt_r    <= 8'd0;
      burst_fixed_r <= 1'b0;
    end else begin
      if (accept_s) begin
        data_r <= s_data_i;
        // Channel and mode are latched only when a burst opens.
        if (beat_cnt_r == 8'd0) begin
          sel_r         <= mode_i ? dest_i : rr_ptr_r;
          burst_fixed_r <= mode_i;
        end
      end
      if (handshake_s) begin
        if (beat_cnt_r == LAST_BEAT) begin
          beat_cnt_r <= 8'd0;
          if (!burst_fixed_r) begin
            rr_ptr_r <= sel_r + 2'd1;
          end
        end else begin
          beat_cnt_r <= beat_cnt_r + 8'd1;
        end
      end
    end
  end

  demux1x4 u_demux (
    .x_i   (state_r == HOLD),
    .sel_i (sel_r),
    .y_o   (m_valid_o)
  );

  assign m_data_o = data_r;
  assign sel_o    = sel_r;
  assign busy_o   = (state_r == HOLD) | (beat_cnt_r != 8'd0);

endmodule
